psw_unit: RTL and testbench
===========================

PSW_UNIT -- requirements
Module: psw_unit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; ports SHALL be named clk and reset.
REQ-002 Ports SHALL be (name  direction  width  meaning):
 clk  in  1  rising-edge clock
 reset  in  1  sync active-high reset
 alu_c, alu_a, alu_z, alu_s, alu_p  in  1 each  flag results from the 8080 ALU
 flag_we  in  1  load S,Z,AC,P,CY from ALU inputs
 flag_we_nc  in  1  load S,Z,AC,P only; CY kept (INR/DCR)
 stc  in  1  set CY
 cmc  in  1  complement CY
 psw_we  in  1  load flags from psw_in (POP PSW)
 psw_in  in  8  PSW image
 psw_out  out  8  PSW image {S,Z,0,AC,0,P,1,CY}
 carry  out  1  registered CY, drives ALU in_c
 cond  in  3  condition code
 cond_true  out  1  condition evaluation
 daa_start  in  1  start decimal adjust
 daa_acc  in  8  accumulator operand, sampled at start
 daa_busy  out  1  DAA in progress
 daa_done  out  1  one-cycle pulse, result valid
 daa_result  out  8  adjusted accumulator

Function
REQ-003 Flags S,Z,AC,P,CY SHALL be registers; psw_out bits 5,3 SHALL read 0 and bit 1 SHALL read 1.
REQ-004 Flag-write priority per edge SHALL be: psw_we > DAA completion > flag_we > flag_we_nc > stc > cmc; lower-priority requests in the same cycle are dropped.
REQ-005 psw_we SHALL load S=psw_in[7], Z=[6], AC=[4], P=[2], CY=[0]; bits 5,3,1 ignored.
REQ-006 cond_true SHALL be combinational from registered flags: 000 NZ, 001 Z, 010 NC, 011 C, 100 PO (P=0), 101 PE (P=1), 110 P (S=0), 111 M (S=1).
REQ-007 DAA FSM states SHALL be IDLE, ADJ_LO, ADJ_HI; daa_start in IDLE samples daa_acc and registered AC/CY and moves to ADJ_LO.
REQ-008 ADJ_LO: if low nibble > 9 or AC, add 0x06; AC' = carry out of bit 3; move to ADJ_HI.
REQ-009 ADJ_HI: if high nibble > 9 or CY, add 0x60 and set CY'=1, else CY' = sampled CY; move to IDLE with daa_done=1 for that cycle.
REQ-010 Latency: start at edge N SHALL give daa_done and daa_result valid in the cycle after edge N+2; flags S,Z,P (from result), AC', CY' SHALL be written at that same edge, subject to REQ-004.
REQ-011 daa_busy SHALL be 1 in ADJ_LO and ADJ_HI; daa_start while busy SHALL be ignored.
REQ-012 daa_result SHALL hold the last result until the next completion.
REQ-013 8-bit adds SHALL wrap modulo 256.
REQ-014 Flag writes during busy SHALL take effect but SHALL NOT alter the operands sampled at start.

Reset
REQ-015 reset SHALL force S=Z=AC=P=CY=0 (psw_out=0x02, carry=0), FSM=IDLE, daa_busy=0, daa_done=0, daa_result=0x00.
REQ-016 reset mid-DAA SHALL abort with no daa_done and no flag write; reset overrides all writes that cycle.

Structure
REQ-017 A shared package SHALL hold condition-code constants, PSW bit positions, and DAA state encoding.
REQ-018 The nibble-adjust datapath SHALL be one sub-module, psw_daa_adj; FSM and flag registers stay in psw_unit.

Verification
REQ-019 Reset then idle -> psw_out=0x02, carry=0, cond=000 -> cond_true=1.
REQ-020 psw_we with psw_in=0xFF -> psw_out=0xD7, cond=111 -> 1, cond=010 -> 0.
REQ-021 flag_we with CY=1, then flag_we_nc with alu_c=0, alu_z=1 -> CY stays 1, Z=1.
REQ-022 daa_acc=0x9B, AC=0, CY=0, start -> daa_done at N+2, result 0x01, CY=1, AC=1, Z=0, P=0.
REQ-023 psw_we at DAA completion edge -> flags from psw_in, daa_result still 0x01; daa_start while busy ignored.
REQ-024 reset asserted in ADJ_HI -> no daa_done, psw_out=0x02 next cycle.

Source files
------------

// File: rtl/psw_pkg.sv
// Shared definitions for the 8080 processor status word unit: PSW bit positions,
// condition codes, DAA sequencer states and the flag bundle.
package psw_pkg;

  localparam int unsigned PSW_W  = 8;
  localparam int unsigned NIB_W  = 4;
  localparam int unsigned COND_W = 3;

  localparam int unsigned PSW_S   = 7;
  localparam int unsigned PSW_Z   = 6;
  localparam int unsigned PSW_AC  = 4;
  localparam int unsigned PSW_P   = 2;
  localparam int unsigned PSW_ONE = 1;
  localparam int unsigned PSW_CY  = 0;

  localparam logic [COND_W-1:0] COND_NZ = 3'b000;
  localparam logic [COND_W-1:0] COND_Z  = 3'b001;
  localparam logic [COND_W-1:0] COND_NC = 3'b010;
  localparam logic [COND_W-1:0] COND_C  = 3'b011;
  localparam logic [COND_W-1:0] COND_PO = 3'b100;
  localparam logic [COND_W-1:0] COND_PE = 3'b101;
  localparam logic [COND_W-1:0] COND_P  = 3'b110;
  localparam logic [COND_W-1:0] COND_M  = 3'b111;

  typedef enum logic [1:0] {
    DAA_IDLE   = 2'd0,
    DAA_ADJ_LO = 2'd1,
    DAA_ADJ_HI = 2'd2
  } daa_state_e;

  typedef struct packed {
    logic s;
    logic z;
    logic ac;
    logic p;
    logic cy;
  } flags_t;

  // 8080 P flag is set for even parity
  function automatic logic parity_even(input logic [PSW_W-1:0] v);
    return ~(^v);
  endfunction

endpackage

// File: rtl/psw_daa_adj.sv
// Decimal-adjust nibble datapath: low-nibble (+0x06) and high-nibble (+0x60)
// corrections evaluated combinationally on the current accumulator value.
module psw_daa_adj
  import psw_pkg::*;
(
  input  logic [PSW_W-1:0] acc_i,
  input  logic             ac_i,
  input  logic             cy_i,
  output logic [PSW_W-1:0] lo_res_c_o,
  output logic             lo_ac_c_o,
  output logic [PSW_W-1:0] hi_res_c_o,
  output logic             hi_cy_c_o
);

  logic             lo_fix;
  logic             hi_fix;
  logic [NIB_W:0]   lo_sum;

  // Low nibble plus 6 with a spare bit to expose the carry out of bit 3
  assign lo_sum     = {1'b0, acc_i[NIB_W-1:0]} + (NIB_W+1)'(6);
  assign lo_fix     = (acc_i[NIB_W-1:0] > NIB_W'(9)) || ac_i;
  assign lo_res_c_o = lo_fix ? (acc_i + PSW_W'(8'h06)) : acc_i;
  assign lo_ac_c_o  = lo_fix & lo_sum[NIB_W];

  // A set input carry always forces the high correction, so it implies CY'
  assign hi_fix     = (acc_i[PSW_W-1:NIB_W] > NIB_W'(9)) || cy_i;
  assign hi_res_c_o = hi_fix ? (acc_i + PSW_W'(8'h60)) : acc_i;
  assign hi_cy_c_o  = hi_fix;

endmodule

// File: rtl/psw_unit.sv
// 8080 flag register file with condition evaluation and a three-state
// decimal-adjust sequencer that writes its result flags on completion.
module psw_unit
  import psw_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              alu_c,
  input  logic              alu_a,
  input  logic              alu_z,
  input  logic              alu_s,
  input  logic              alu_p,
  input  logic              flag_we,
  input  logic              flag_we_nc,
  input  logic              stc,
  input  logic              cmc,
  input  logic              psw_we,
  input  logic [PSW_W-1:0]  psw_in,
  output logic [PSW_W-1:0]  psw_out,
  output logic              carry,
  input  logic [COND_W-1:0] cond,
  output logic              cond_true,
  input  logic              daa_start,
  input  logic [PSW_W-1:0]  daa_acc,
  output logic              daa_busy,
  output logic              daa_done,
  output logic [PSW_W-1:0]  daa_result
);

  daa_state_e       state_q, state_d;
  flags_t           flags_q, flags_d;
  flags_t           daa_flags;
  logic [PSW_W-1:0] acc_q, acc_d;
  logic             ac_s_q, ac_s_d;
  logic             cy_s_q, cy_s_d;
  logic             done_q, done_d;
  logic [PSW_W-1:0] result_q, result_d;
  logic             daa_fin;

  logic [PSW_W-1:0] lo_res;
  logic             lo_ac;
  logic [PSW_W-1:0] hi_res;
  logic             hi_cy;

  // Reserved PSW image bits are read-only constants
  logic unused_psw_bits;
  assign unused_psw_bits = ^{psw_in[5], psw_in[3], psw_in[PSW_ONE]};

  psw_daa_adj u_adj (
    .acc_i      (acc_q),
    .ac_i       (ac_s_q),
    .cy_i       (cy_s_q),
    .lo_res_c_o (lo_res),
    .lo_ac_c_o  (lo_ac),
    .hi_res_c_o (hi_res),
    .hi_cy_c_o  (hi_cy)
  );

  assign daa_flags = '{s:  hi_res[PSW_W-1],
                       z:  (hi_res == '0),
                       ac: ac_s_q,
                       p:  parity_even(hi_res),
                       cy: hi_cy};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= DAA_IDLE;
      flags_q  <= '0;
      acc_q    <= '0;
      ac_s_q   <= 1'b0;
      cy_s_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      flags_q  <= flags_d;
      acc_q    <= acc_d;
      ac_s_q   <= ac_s_d;
      cy_s_q   <= cy_s_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    flags_d  = flags_q;
    acc_d    = acc_q;
    ac_s_d   = ac_s_q;
    cy_s_d   = cy_s_q;
    done_d   = 1'b0;
    result_d = result_q;
    daa_fin  = 1'b0;

    // ac_s_q holds the sampled AC until ADJ_LO replaces it with AC'
    case (state_q)
      DAA_IDLE: begin
        if (daa_start) begin
          acc_d   = daa_acc;
          ac_s_d  = flags_q.ac;
          cy_s_d  = flags_q.cy;
          state_d = DAA_ADJ_LO;
        end
      end
      DAA_ADJ_LO: begin
        acc_d   = lo_res;
        ac_s_d  = lo_ac;
        state_d = DAA_ADJ_HI;
      end
      DAA_ADJ_HI: begin
        result_d = hi_res;
        done_d   = 1'b1;
        daa_fin  = 1'b1;
        state_d  = DAA_IDLE;
      end
      default: state_d = DAA_IDLE;
    endcase

    // Single flag writer per edge; lower-priority requests are dropped
    if (psw_we) begin
      flags_d = '{s:  psw_in[PSW_S],
                  z:  psw_in[PSW_Z],
                  ac: psw_in[PSW_AC],
                  p:  psw_in[PSW_P],
                  cy: psw_in[PSW_CY]};
    end else if (daa_fin) begin
      flags_d = daa_flags;
    end else if (flag_we) begin
      flags_d = '{s: alu_s, z: alu_z, ac: alu_a, p: alu_p, cy: alu_c};
    end else if (flag_we_nc) begin
      flags_d = '{s: alu_s, z: alu_z, ac: alu_a, p: alu_p, cy: flags_q.cy};
    end else if (stc) begin
      flags_d.cy = 1'b1;
    end else if (cmc) begin
      flags_d.cy = ~flags_q.cy;
    end
  end

  always_comb begin
    cond_true = 1'b0;
    case (cond)
      COND_NZ: cond_true = ~flags_q.z;
      COND_Z:  cond_true =  flags_q.z;
      COND_NC: cond_true = ~flags_q.cy;
      COND_C:  cond_true =  flags_q.cy;
      COND_PO: cond_true = ~flags_q.p;
      COND_PE: cond_true =  flags_q.p;
      COND_P:  cond_true = ~flags_q.s;
      COND_M:  cond_true =  flags_q.s;
      default: cond_true = 1'b0;
    endcase
  end

  assign psw_out    = {flags_q.s, flags_q.z, 1'b0, flags_q.ac,
                       1'b0, flags_q.p, 1'b1, flags_q.cy};
  assign carry      = flags_q.cy;
  assign daa_busy   = (state_q != DAA_IDLE);
  assign daa_done   = done_q;
  assign daa_result = result_q;

endmodule

// File: tb/tb_psw_unit.sv
// Bench for psw_unit: flag-write vector table, hand-written DAA corner sequences,
// and a randomized run against a cycle-level behavioural model.
module tb_psw_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic       alu_c, alu_a, alu_z, alu_s, alu_p;
  logic       flag_we, flag_we_nc, stc, cmc, psw_we;
  logic [7:0] psw_in;
  logic [7:0] psw_out;
  logic       carry;
  logic [2:0] cond;
  logic       cond_true;
  logic       daa_start;
  logic [7:0] daa_acc;
  logic       daa_busy, daa_done;
  logic [7:0] daa_result;

  int checks = 0;
  int failures = 0;

  psw_unit dut (
    .clk(clk), .reset(reset),
    .alu_c(alu_c), .alu_a(alu_a), .alu_z(alu_z), .alu_s(alu_s), .alu_p(alu_p),
    .flag_we(flag_we), .flag_we_nc(flag_we_nc), .stc(stc), .cmc(cmc),
    .psw_we(psw_we), .psw_in(psw_in), .psw_out(psw_out), .carry(carry),
    .cond(cond), .cond_true(cond_true),
    .daa_start(daa_start), .daa_acc(daa_acc), .daa_busy(daa_busy),
    .daa_done(daa_done), .daa_result(daa_result)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%02h exp=%02h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    {alu_c, alu_a, alu_z, alu_s, alu_p} = '0;
    {flag_we, flag_we_nc, stc, cmc, psw_we} = '0;
    psw_in = 8'h00; cond = 3'b000; daa_start = 1'b0; daa_acc = 8'h00;
  endtask

  // Reference DAA from the 8080 decimal-adjust rule: returns {CY', AC', result}
  function automatic logic [9:0] daa_ref(input logic [7:0] a, input logic ac, input logic cy);
    int r = int'(a);
    logic acn = 1'b0, cyn = cy;
    if ((r % 16) > 9 || ac) begin
      acn = ((r % 16) + 6) > 15;
      r = (r + 6) % 256;
    end
    if ((r / 16) > 9 || cy) begin
      r = (r + 96) % 256;
      cyn = 1'b1;
    end
    return {cyn, acn, 8'(r)};
  endfunction

  // Behavioural model state
  logic m_s, m_z, m_ac, m_p, m_cy;
  int   m_left;                       // edges until DAA completion, 0 = idle
  logic [7:0] m_acc, m_res;
  logic m_ac0, m_cy0, m_done;

  function automatic logic [7:0] m_psw();
    return {m_s, m_z, 1'b0, m_ac, 1'b0, m_p, 1'b1, m_cy};
  endfunction

  function automatic logic m_cond(input logic [2:0] c);
    case (c)
      3'd0: return !m_z;
      3'd1: return m_z;
      3'd2: return !m_cy;
      3'd3: return m_cy;
      3'd4: return !m_p;
      3'd5: return m_p;
      3'd6: return !m_s;
      default: return m_s;
    endcase
  endfunction

  task automatic model_step();
    logic [9:0] r;
    logic fin;
    if (reset) begin
      {m_s, m_z, m_ac, m_p, m_cy} = '0;
      m_left = 0; m_res = 8'h00; m_done = 1'b0;
      return;
    end
    fin = (m_left == 1);
    r = daa_ref(m_acc, m_ac0, m_cy0);
    if (m_left > 0) m_left--;
    else if (daa_start) begin
      m_left = 2; m_acc = daa_acc; m_ac0 = m_ac; m_cy0 = m_cy;
    end
    m_done = fin;
    if (fin) m_res = r[7:0];
    if (psw_we) {m_s, m_z, m_ac, m_p, m_cy} = {psw_in[7], psw_in[6], psw_in[4], psw_in[2], psw_in[0]};
    else if (fin) {m_s, m_z, m_ac, m_p, m_cy} = {r[7], r[7:0] == 8'h00, r[8], ~^r[7:0], r[9]};
    else if (flag_we) {m_s, m_z, m_ac, m_p, m_cy} = {alu_s, alu_z, alu_a, alu_p, alu_c};
    else if (flag_we_nc) {m_s, m_z, m_ac, m_p} = {alu_s, alu_z, alu_a, alu_p};
    else if (stc) m_cy = 1'b1;
    else if (cmc) m_cy = !m_cy;
  endtask

  typedef struct {
    logic       psw_we;
    logic [7:0] psw_in;
    logic       flag_we, flag_we_nc, stc, cmc;
    logic [4:0] alu;        // {s, z, a, p, c}
    logic [2:0] cond;
    logic [7:0] exp_psw;
    logic       exp_cond;
  } vec_t;

  vec_t vecs[12];

  task automatic do_reset();
    @(negedge clk); idle_inputs(); reset = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    @(negedge clk); reset = 1'b0;
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    vecs[0]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 5'b00000, 3'd0, 8'h02, 1'b1};
    vecs[1]  = '{1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 5'b00000, 3'd7, 8'hD7, 1'b1};
    vecs[2]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 5'b00000, 3'd2, 8'hD7, 1'b0};
    vecs[3]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 5'b00001, 3'd3, 8'h03, 1'b1};
    vecs[4]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 5'b01000, 3'd1, 8'h43, 1'b1};
    vecs[5]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 5'b00000, 3'd2, 8'h43, 1'b0};
    vecs[6]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 5'b00000, 3'd2, 8'h42, 1'b1};
    vecs[7]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 5'b00000, 3'd0, 8'h02, 1'b1};
    vecs[8]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 5'b10110, 3'd4, 8'h96, 1'b0};
    vecs[9]  = '{1'b1, 8'h28, 1'b1, 1'b0, 1'b0, 1'b0, 5'b11111, 3'd5, 8'h02, 1'b0};
    vecs[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 5'b00000, 3'd6, 8'h02, 1'b1};
    vecs[11] = '{1'b1, 8'h81, 1'b0, 1'b0, 1'b0, 1'b0, 5'b00000, 3'd7, 8'h83, 1'b1};

    do_reset();
    #1;
    check("rst_psw", psw_out, 8'h02);
    check("rst_carry", {7'd0, carry}, 8'h00);
    check("rst_busy", {7'd0, daa_busy}, 8'h00);
    check("rst_done", {7'd0, daa_done}, 8'h00);
    check("rst_result", daa_result, 8'h00);

    // Flag-write priority table
    foreach (vecs[i]) begin
      @(negedge clk);
      psw_we = vecs[i].psw_we; psw_in = vecs[i].psw_in;
      flag_we = vecs[i].flag_we; flag_we_nc = vecs[i].flag_we_nc;
      stc = vecs[i].stc; cmc = vecs[i].cmc;
      {alu_s, alu_z, alu_a, alu_p, alu_c} = vecs[i].alu;
      cond = vecs[i].cond;
      @(posedge clk); #1;
      check($sformatf("vec%0d_psw", i), psw_out, vecs[i].exp_psw);
      check($sformatf("vec%0d_cond", i), {7'd0, cond_true}, {7'd0, vecs[i].exp_cond});
      check($sformatf("vec%0d_carry", i), {7'd0, carry}, {7'd0, vecs[i].exp_psw[0]});
    end

    // DAA of 0x9B with AC=CY=0: 0x01, CY=1, AC=1, Z=0, P=0
    do_reset();
    daa_start = 1'b1; daa_acc = 8'h9B;
    @(posedge clk); #1;
    check("daa1_busy_n", {7'd0, daa_busy}, 8'h01);
    @(negedge clk); daa_start = 1'b0; daa_acc = 8'h00;
    @(posedge clk); #1;
    check("daa1_busy_n1", {7'd0, daa_busy}, 8'h01);
    check("daa1_done_n1", {7'd0, daa_done}, 8'h00);
    @(posedge clk); #1;
    check("daa1_done", {7'd0, daa_done}, 8'h01);
    check("daa1_result", daa_result, 8'h01);
    check("daa1_psw", psw_out, 8'h13);
    check("daa1_busy_end", {7'd0, daa_busy}, 8'h00);
    @(posedge clk); #1;
    check("daa1_done_pulse", {7'd0, daa_done}, 8'h00);
    check("daa1_result_hold", daa_result, 8'h01);

    // psw_we at completion wins; start while busy is ignored
    @(negedge clk); daa_start = 1'b1; daa_acc = 8'h9B;
    @(posedge clk);
    @(negedge clk); daa_acc = 8'h00;
    @(posedge clk); #1;
    check("daa2_busy", {7'd0, daa_busy}, 8'h01);
    @(negedge clk); daa_start = 1'b0; psw_we = 1'b1; psw_in = 8'h40;
    @(posedge clk); #1;
    check("daa2_done", {7'd0, daa_done}, 8'h01);
    check("daa2_result", daa_result, 8'h01);
    check("daa2_psw", psw_out, 8'h42);
    @(negedge clk); psw_we = 1'b0;
    @(posedge clk); #1;
    check("daa2_no_restart", {7'd0, daa_busy}, 8'h00);
    check("daa2_done_pulse", {7'd0, daa_done}, 8'h00);

    // Reset in ADJ_HI aborts the adjust and overrides a simultaneous psw_we
    @(negedge clk); daa_start = 1'b1; daa_acc = 8'h9B;
    @(posedge clk);
    @(negedge clk); daa_start = 1'b0;
    @(posedge clk);
    @(negedge clk); reset = 1'b1; psw_we = 1'b1; psw_in = 8'hFF;
    @(posedge clk); #1;
    check("abort_done", {7'd0, daa_done}, 8'h00);
    check("abort_psw", psw_out, 8'h02);
    check("abort_busy", {7'd0, daa_busy}, 8'h00);
    check("abort_result", daa_result, 8'h00);
    @(negedge clk); reset = 1'b0; psw_we = 1'b0;
    @(posedge clk); #1;
    check("abort_done_after", {7'd0, daa_done}, 8'h00);

    // Randomized run against the behavioural model
    do_reset();
    {m_s, m_z, m_ac, m_p, m_cy} = '0;
    m_left = 0; m_res = 8'h00; m_done = 1'b0;
    m_acc = 8'h00; m_ac0 = 1'b0; m_cy0 = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      reset = ($urandom_range(63) == 0);
      {alu_c, alu_a, alu_z, alu_s, alu_p} = 5'($urandom);
      flag_we    = ($urandom_range(5) == 0);
      flag_we_nc = ($urandom_range(5) == 0);
      stc        = ($urandom_range(5) == 0);
      cmc        = ($urandom_range(4) == 0);
      psw_we     = ($urandom_range(9) == 0);
      psw_in     = 8'($urandom);
      cond       = 3'($urandom);
      daa_start  = ($urandom_range(2) == 0);
      daa_acc    = 8'($urandom);
      #1;
      check("rnd_psw", psw_out, m_psw());
      check("rnd_carry", {7'd0, carry}, {7'd0, m_cy});
      check("rnd_cond", {7'd0, cond_true}, {7'd0, m_cond(cond)});
      check("rnd_busy", {7'd0, daa_busy}, {7'd0, m_left != 0});
      check("rnd_done", {7'd0, daa_done}, {7'd0, m_done});
      check("rnd_result", daa_result, m_res);
      model_step();
      @(posedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
